pin_entry_buffer: RTL and testbench



---
 rtl/pin_entry_buffer_pkg.sv | 31 +++
 rtl/pin_entry_buffer.sv | 149 ++++++++++++++
 tb/tb_pin_entry_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pin_entry_buffer_pkg.sv
// Shared types and key/display codes for the PIN entry keypad buffer.
// A packet holds six BCD nibbles; index 0 is the newest digit.
package pin_entry_buffer_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [NUM_DIGITS-1:0][3:0] bcdPac_t;

   localparam logic [3:0] KEY_BACK  = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;
   localparam logic [3:0] BCD_DASH  = 4'hA;
   localparam logic [3:0] BCD_BLANK = 4'hB;

   localparam bcdPac_t BLANK_PAC = {NUM_DIGITS{BCD_BLANK}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_SEND  = 2'd2
   } state_e;

   // Occupied positions become dashes; the newest may stay in clear.
   function automatic bcdPac_t mask_packet(input bcdPac_t d, input logic show0);
      bcdPac_t p;
      for (int i = 0; i < NUM_DIGITS; i++)
         p[i] = (d[i] == BCD_BLANK) ? BCD_BLANK : BCD_DASH;
      if (show0 && d[0] != BCD_BLANK) p[0] = d[0];
      return p;
   endfunction

endpackage

// File: rtl/pin_entry_buffer.sv
// Keypad PIN entry: six-digit shift buffer with masked display, idle
// timeout and a valid/ready handoff of the submitted PIN.
module pin_entry_buffer
   import pin_entry_buffer_pkg::*;
#(
   parameter int MIN_DIGITS     = 4,
   parameter int MASK_CYCLES    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 250_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       pin_ready,
   output bcdPac_t    bcd_packet,
   output logic       enable_o,
   output logic       pin_valid,
   output bcdPac_t    pin_out,
   output logic [2:0] pin_len
);

   localparam int MW = $clog2(MASK_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   bcdPac_t       dig_q, dig_d;
   logic          clr_q, clr_d;
   logic [MW-1:0] mask_q, mask_d;
   logic [TW-1:0] tmo_q, tmo_d;
   bcdPac_t       pout_q, pout_d;
   logic [2:0]    plen_q, plen_d;
   bcdPac_t       bcd_q;
   logic          en_q, pv_q;
   logic          is_digit;

   assign is_digit = (key_code <= 4'd9);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      clr_d   = clr_q;
      mask_d  = mask_q;
      tmo_d   = tmo_q;
      pout_d  = pout_q;
      plen_d  = plen_q;
      unique case (state_q)
         ST_IDLE: begin
            if (key_valid && is_digit) begin
               dig_d    = BLANK_PAC;
               dig_d[0] = key_code;
               cnt_d    = 3'd1;
               clr_d    = 1'b1;
               mask_d   = MW'(MASK_CYCLES - 1);
               tmo_d    = '0;
               state_d  = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            // clear-text window of the newest digit runs down every cycle
            if (clr_q) begin
               if (mask_q == '0) clr_d = 1'b0;
               else              mask_d = mask_q - MW'(1);
            end
            if (key_valid) begin
               tmo_d = '0;
               if (is_digit) begin
                  if (cnt_q < 3'(NUM_DIGITS)) begin
                     dig_d  = {dig_q[NUM_DIGITS-2:0], key_code};
                     cnt_d  = cnt_q + 3'd1;
                     clr_d  = 1'b1;
                     mask_d = MW'(MASK_CYCLES - 1);
                  end
               end else if (key_code == KEY_BACK) begin
                  dig_d = {BCD_BLANK, dig_q[NUM_DIGITS-1:1]};
                  cnt_d = cnt_q - 3'd1;
                  clr_d = 1'b0;
                  if (cnt_q == 3'd1) state_d = ST_IDLE;
               end else if (key_code == KEY_ENTER) begin
                  if (cnt_q >= 3'(MIN_DIGITS)) begin
                     pout_d  = dig_q;
                     plen_d  = cnt_q;
                     clr_d   = 1'b0;
                     state_d = ST_SEND;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_SEND: begin
            if (pin_ready) begin
               pout_d  = BLANK_PAC;
               plen_d  = 3'd0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // any path into IDLE drops the whole entry
      if (state_d == ST_IDLE) begin
         dig_d  = BLANK_PAC;
         cnt_d  = 3'd0;
         clr_d  = 1'b0;
         mask_d = '0;
         tmo_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         dig_q   <= BLANK_PAC;
         clr_q   <= 1'b0;
         mask_q  <= '0;
         tmo_q   <= '0;
         pout_q  <= BLANK_PAC;
         plen_q  <= 3'd0;
         bcd_q   <= BLANK_PAC;
         en_q    <= 1'b0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         clr_q   <= clr_d;
         mask_q  <= mask_d;
         tmo_q   <= tmo_d;
         pout_q  <= pout_d;
         plen_q  <= plen_d;
         bcd_q   <= mask_packet(dig_d, clr_d);
         en_q    <= (state_d != ST_IDLE);
         pv_q    <= (state_d == ST_SEND);
      end
   end

   assign bcd_packet = bcd_q;
   assign enable_o   = en_q;
   assign pin_valid  = pv_q;
   assign pin_out    = pout_q;
   assign pin_len    = plen_q;

endmodule

// File: tb/tb_pin_entry_buffer.sv
// Scoreboard bench for pin_entry_buffer: a queue-based PIN model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_pin_entry_buffer;
   import pin_entry_buffer_pkg::*;

   localparam int MIN = 4;
   localparam int MASK = 3;
   localparam int TMO = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       pin_ready = 1'b0;
   bcdPac_t    bcd_packet;
   logic       enable_o;
   logic       pin_valid;
   bcdPac_t    pin_out;
   logic [2:0] pin_len;

   pin_entry_buffer #(.MIN_DIGITS(MIN), .MASK_CYCLES(MASK), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .pin_ready(pin_ready), .bcd_packet(bcd_packet), .enable_o(enable_o),
      .pin_valid(pin_valid), .pin_out(pin_out), .pin_len(pin_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] bcd;
      logic        en;
      logic        pv;
      logic [23:0] pout;
      logic [2:0]  plen;
   } exp_t;

   exp_t expq[$];
   int checks = 0;
   int errors = 0;

   // reference model: 0 idle, 1 entry, 2 send; digs[0] is the newest digit
   int          mst = 0;
   int          digs[$];
   int          edge_n = 0;
   int          last_key = 0;
   int          dig_edge = 0;
   bit          fresh = 0;
   logic [23:0] m_pout = 24'hBBBBBB;
   int          m_plen = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pack_digits();
      logic [23:0] p;
      for (int i = 0; i < 6; i++)
         p[i*4 +: 4] = (i < digs.size()) ? 4'(digs[i]) : 4'hB;
      return p;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         if (i >= digs.size())
            e.bcd[i*4 +: 4] = 4'hB;
         else if (i == 0 && mst == 1 && fresh && (edge_n - dig_edge) < MASK)
            e.bcd[i*4 +: 4] = 4'(digs[0]);
         else
            e.bcd[i*4 +: 4] = 4'hA;
      end
      e.en   = (mst != 0);
      e.pv   = (mst == 2);
      e.pout = m_pout;
      e.plen = 3'(m_plen);
      return e;
   endfunction

   task automatic model_reset();
      mst = 0; digs.delete(); fresh = 0; m_pout = 24'hBBBBBB; m_plen = 0;
   endtask

   task automatic model(input bit rn, input bit kv, input logic [3:0] kc, input bit pr);
      edge_n++;
      if (!rn) begin
         model_reset();
         return;
      end
      case (mst)
         0: if (kv && kc <= 4'd9) begin
               digs.delete(); digs.push_front(int'(kc));
               dig_edge = edge_n; fresh = 1; last_key = edge_n; mst = 1;
            end
         1: if (kv) begin
               last_key = edge_n;
               if (kc <= 4'd9) begin
                  if (digs.size() < 6) begin
                     digs.push_front(int'(kc)); dig_edge = edge_n; fresh = 1;
                  end
               end else if (kc == 4'hA) begin
                  void'(digs.pop_front()); fresh = 0;
                  if (digs.size() == 0) mst = 0;
               end else if (kc == 4'hB) begin
                  if (digs.size() >= MIN) begin
                     m_pout = pack_digits(); m_plen = digs.size(); mst = 2;
                  end else begin
                     digs.delete(); mst = 0;
                  end
               end
            end else if (edge_n - last_key >= TMO) begin
               digs.delete(); mst = 0;
            end
         2: if (pr) begin
               digs.delete(); m_pout = 24'hBBBBBB; m_plen = 0; mst = 0;
            end
         default: mst = 0;
      endcase
   endtask

   task automatic step(input bit rn, input bit kv, input logic [3:0] kc, input bit pr);
      @(negedge clk);
      rst = rn; key_valid = kv; key_code = kc; pin_ready = pr;
      @(posedge clk);
      model(rn, kv, kc, pr);
      expq.push_back(snap());
   endtask

   task automatic key(input logic [3:0] kc);
      step(1, 1, kc, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1, 0, 4'h0, 0);
   endtask

   // reset asserted mid-cycle must clear outputs without waiting for a clock
   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_pin_valid", {31'd0, pin_valid}, 32'd0);
      check("async_rst_enable", {31'd0, enable_o}, 32'd0);
      check("async_rst_bcd", {8'd0, bcd_packet}, {8'd0, 24'hBBBBBB});
      check("async_rst_pin_out", {8'd0, pin_out}, {8'd0, 24'hBBBBBB});
      check("async_rst_pin_len", {29'd0, pin_len}, 32'd0);
      model_reset();
      step(0, 0, 4'h0, 0);
      step(1, 0, 4'h0, 0);
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         check("bcd_packet", {8'd0, bcd_packet}, {8'd0, e.bcd});
         check("enable_o", {31'd0, enable_o}, {31'd0, e.en});
         check("pin_valid", {31'd0, pin_valid}, {31'd0, e.pv});
         check("pin_out", {8'd0, pin_out}, {8'd0, e.pout});
         check("pin_len", {29'd0, pin_len}, {29'd0, e.plen});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      bit kv, pr;
      logic [3:0] kc;
      step(0, 0, 4'h0, 0);
      step(0, 1, 4'h3, 1);
      step(1, 0, 4'h0, 0);
      // full PIN, held until pin_ready; stray pin_ready/back/enter in IDLE
      step(1, 0, 4'h0, 1);
      key(4'hA); key(4'hB); key(4'hE);
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
      idle(2);
      step(1, 0, 4'h0, 1);
      idle(2);
      // mask timing and dash on older digit
      key(4'h7); idle(5); key(4'h8); idle(1);
      key(4'hA); key(4'hA); idle(1);
      // overflow and backspace
      for (int i = 1; i <= 7; i++) key(4'(i));
      key(4'hA); idle(1); key(4'hF); idle(2);
      for (int i = 0; i < 5; i++) key(4'hA);
      idle(1);
      // short PIN rejected
      key(4'h5); key(4'h6); key(4'hB); idle(2);
      // timeout, then a key one cycle before expiry
      key(4'h9); idle(22);
      key(4'h1); idle(18); key(4'h2); idle(19); step(1, 1, 4'hC, 0); idle(21);
      // key during SEND ignored, then reset mid-SEND
      for (int i = 1; i <= 6; i++) key(4'(i));
      key(4'hB); key(4'h9); key(4'hA); idle(2);
      async_reset();
      idle(2);
      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 199);
         if (r < 2) begin
            async_reset();
         end else if (r < 8) begin
            repeat (22) step(1, 0, 4'h0, ($urandom_range(0, 9) == 0));
         end else begin
            kv = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 99);
            if (r < 60)      kc = 4'($urandom_range(0, 9));
            else if (r < 75) kc = 4'hA;
            else if (r < 90) kc = 4'hB;
            else             kc = 4'($urandom_range(12, 15));
            pr = ($urandom_range(0, 3) == 0);
            step(1, kv, kc, pr);
         end
      end
      idle(3);
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
